// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single outstanding reads to
// instruction memory and holds the fetched word in IR until decode takes it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] IR,
    output logic [31:0] ir_pc,
    output logic [31:0] ir_pc4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misalign
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ir_entry_t;

    state_t      state, state_n;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;
    ir_entry_t   ir_q;
    logic        capture;
    logic        consume;

    assign pc_plus4         = pc + 32'd4;
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    // Request is masked during reset so memory never sees a fetch while the
    // PC is being forced.
    assign imem_req  = (state == REQ) && !rst;
    assign imem_addr = pc;
    assign IR        = ir_q.word;
    assign ir_pc     = ir_q.pc;
    assign ir_pc4    = ir_q.pc4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= REQ;
        else     state <= state_n;
    end

    // Redirect outranks everything; the only question is whether a response
    // is still owed by memory, which decides between REQ and DROP.
    always_comb begin
        state_n = state;
        capture = 1'b0;
        consume = 1'b0;
        case (state)
            REQ: begin
                if (redirect)        state_n = imem_ready ? DROP : REQ;
                else if (imem_ready) state_n = WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    state_n = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    state_n = HOLD;
                    capture = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_n = REQ;
                end else if (ir_ready) begin
                    state_n = REQ;
                    consume = 1'b1;
                end
            end
            DROP: begin
                if (imem_rvalid) state_n = REQ;
            end
            default: state_n = REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir_q     <= '0;
            ir_valid <= 1'b0;
            misalign <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_aligned;
            ir_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) misalign <= 1'b1;
        end else if (capture) begin
            ir_q     <= '{word: imem_rdata, pc: pc, pc4: pc_plus4};
            pc       <= pc_plus4;
            ir_valid <= 1'b1;
        end else if (consume) begin
            ir_valid <= 1'b0;
        end
    end

endmodule
